alu_fault_pipe: RTL and testbench
=================================

ALU_FAULT_PIPE -- requirements
Module: alu_fault_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (>=8, power of two).
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount and fault-bit index width, equal to log2(WIDTH).
REQ-003 SHALL have parameter ERRCNT_W, default 8, error-counter width.
REQ-004 Ports: clock  in  1  sole clock, all state on rising edge.
REQ-005 Ports: resetn  in  1  asynchronous, active-low reset.
REQ-006 Ports: in_valid in 1 / in_ready out 1  operation-input handshake.
REQ-007 Ports: data_operandA, data_operandB  in  WIDTH  operands.
REQ-008 Ports: ctrl_ALUopcode in 5 (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA); ctrl_shiftamt in SHAMT_W.
REQ-009 Ports: fault_arm in 1  load fault descriptor; fault_sel in 2 (0 adder-sum bit, 1 shamt bit 0, 2 result bit, 3 none); fault_bit in SHAMT_W  target bit index.
REQ-010 Ports: out_valid out 1 / out_ready in 1  result handshake.
REQ-011 Ports: data_result out WIDTH; isNotEqual out 1; isLessThan out 1; fault_detected out 1  per-result checker mismatch.
REQ-012 Ports: clear_err in 1; err_sticky out 1; err_count out ERRCNT_W.

Function
REQ-013 Pipeline SHALL be two stages: S1 captures operands/opcode/shamt/fault tag on in_valid&&in_ready; S2 captures computed result and flags.
REQ-014 Latency SHALL be exactly 2 cycles from input acceptance to out_valid with out_ready held high; throughput one op per cycle.
REQ-015 S2 SHALL advance when S2 empty or out_valid&&out_ready; S1 SHALL advance when S1 empty or S2 advances; in_ready = !S1_valid || S1 advances (combinational, no bubble).
REQ-016 While out_valid&&!out_ready, data_result, flags and fault_detected SHALL hold stable.
REQ-017 ADD = A+B, SUB = A+~B+1, modulo 2^WIDTH, no overflow output; AND/OR bitwise; SLL/SRA shift A by ctrl_shiftamt, SRA sign-fills.
REQ-018 Opcodes 6..31 SHALL yield data_result = 0 and fault_detected = 0.
REQ-019 isNotEqual = (A != B) and isLessThan = signed(A) < signed(B) for every opcode, computed from the unfaulted subtraction, correct at overflow (A=0x80000000,B=1 -> isLessThan=1).
REQ-020 Fault FSM states: IDLE (no fault armed), ARMED (descriptor held).
REQ-021 IDLE -> ARMED on fault_arm with fault_sel!=3; ARMED + fault_arm reloads descriptor; fault_arm with fault_sel=3 -> IDLE.
REQ-022 ARMED -> IDLE on input acceptance; that accepted op SHALL carry the descriptor (one-shot injection); fault_arm in same cycle arms the new descriptor for the following op.
REQ-023 fault_arm in IDLE coincident with acceptance SHALL NOT affect the op accepted that cycle.
REQ-024 Injection: sel 0 inverts sum bit fault_bit (ADD/SUB result only); sel 1 inverts shamt bit 0 (SLL/SRA only); sel 2 inverts data_result bit fault_bit for any opcode 0..5.
REQ-025 Checker SHALL recompute the result through an independent fault-free path; fault_detected = faulted result != reference result, registered with S2.
REQ-026 Masked faults (e.g. sel 1 with A=0, sel 0 on AND) SHALL give fault_detected = 0.
REQ-027 On out_valid&&out_ready&&fault_detected: err_sticky <= 1, err_count increments, saturating at all-ones.
REQ-028 clear_err SHALL zero err_sticky and err_count; a detection transferred in the same cycle SHALL leave count = 1, sticky = 1.

Reset
REQ-029 resetn low SHALL immediately clear S1/S2 valid, out_valid=0, data_result=0, isNotEqual=0, isLessThan=0, fault_detected=0, err_sticky=0, err_count=0, FSM=IDLE; in_ready=1 after reset.
REQ-030 Reset mid-operation SHALL discard in-flight ops and any armed fault; no output transfer reported for them.

Verification
REQ-031 ADD A=0x7FFFFFFF,B=1 accepted cycle 0, out_ready=1 -> cycle 2 out_valid=1, result 0x80000000, isNotEqual=1, isLessThan=0, fault_detected=0.
REQ-032 Arm sel=0 bit=3, then SUB A=10,B=3 -> result 0x0000000F, fault_detected=1, err_count=1; next identical SUB -> 7, fault_detected=0.
REQ-033 Arm sel=1, SRA A=0x80000000 shamt=4 -> result 0xFC000000 (shift 5), fault_detected=1; same with A=0 -> 0, fault_detected=0, err_count unchanged.
REQ-034 Stream 4 ops with out_ready low cycles 2-4 -> in_ready low once both stages full, no op lost or duplicated, order preserved, outputs stable while stalled.
REQ-035 ERRCNT_W=2, four detected faults -> err_count=3 saturated; clear_err with fifth detection same cycle -> err_count=1, err_sticky=1.
REQ-036 Assert resetn low with both stages valid and FSM ARMED -> out_valid=0, err_count=0, FSM IDLE immediately; next op after release unfaulted.

Source files
------------

// File: rtl/alu_fault_pipe.sv
// alu_fault_pipe: two-stage ALU with one-shot fault injection,
// an independent reference checker and sticky error accounting.
module alu_fault_pipe #(
    parameter int WIDTH    = 32,
    parameter int SHAMT_W  = 5,
    parameter int ERRCNT_W = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    data_operandA,
    input  logic [WIDTH-1:0]    data_operandB,
    input  logic [4:0]          ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0]  ctrl_shiftamt,
    input  logic                fault_arm,
    input  logic [1:0]          fault_sel,
    input  logic [SHAMT_W-1:0]  fault_bit,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    data_result,
    output logic                isNotEqual,
    output logic                isLessThan,
    output logic                fault_detected,
    input  logic                clear_err,
    output logic                err_sticky,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SLL = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd5;
    localparam logic [1:0] SEL_NONE = 2'd3;

    typedef enum logic {IDLE, ARMED} fstate_t;

    fstate_t              state, state_nx;
    logic [1:0]           arm_sel, sel_nx;
    logic [SHAMT_W-1:0]   arm_bit, bit_nx;

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_a, s1_b;
    logic [4:0]           s1_op;
    logic [SHAMT_W-1:0]   s1_shamt;
    logic [1:0]           s1_fsel;
    logic [SHAMT_W-1:0]   s1_fbit;

    logic                 s2_adv, s1_adv, accept, xfer_det;
    logic [WIDTH-1:0]     b_eff, sum_f, diff, bit_mask, res_f, res_ref;
    logic [SHAMT_W-1:0]   shamt_f;
    logic                 is_sub, ne_c, lt_c;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;
    assign xfer_det = out_valid && out_ready && fault_detected;

    // Fault descriptor register and arm/disarm state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            arm_sel <= SEL_NONE;
            arm_bit <= '0;
        end else begin
            state   <= state_nx;
            arm_sel <= sel_nx;
            arm_bit <= bit_nx;
        end
    end

    // Arming wins over the one-shot consume so a new fault queues for the next op
    always_comb begin
        state_nx = state;
        sel_nx   = arm_sel;
        bit_nx   = arm_bit;
        if (fault_arm) begin
            if (fault_sel != SEL_NONE) begin
                state_nx = ARMED;
                sel_nx   = fault_sel;
                bit_nx   = fault_bit;
            end else begin
                state_nx = IDLE;
            end
        end else if (state == ARMED && accept) begin
            state_nx = IDLE;
        end
    end

    // Stage 1: capture operands and the fault tag of the accepted op
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_shamt <= '0;
            s1_fsel  <= SEL_NONE;
            s1_fbit  <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= data_operandA;
                s1_b     <= data_operandB;
                s1_op    <= ctrl_ALUopcode;
                s1_shamt <= ctrl_shiftamt;
                s1_fsel  <= (state == ARMED) ? arm_sel : SEL_NONE;
                s1_fbit  <= arm_bit;
            end
        end
    end

    // Faultable datapath, fault-free reference and comparison flags
    always_comb begin
        is_sub   = (s1_op == OP_SUB);
        bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << s1_fbit;
        b_eff    = is_sub ? ~s1_b : s1_b;
        sum_f    = s1_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
        if (s1_fsel == 2'd0) sum_f = sum_f ^ bit_mask;
        shamt_f  = s1_shamt;
        if (s1_fsel == 2'd1) shamt_f[0] = ~shamt_f[0];
        res_f    = '0;
        res_ref  = '0;
        unique case (1'b1)
            s1_op == OP_ADD: begin
                res_f   = sum_f;
                res_ref = s1_a + s1_b;
            end
            s1_op == OP_SUB: begin
                res_f   = sum_f;
                res_ref = s1_a - s1_b;
            end
            s1_op == OP_AND: begin
                res_f   = s1_a & s1_b;
                res_ref = s1_a & s1_b;
            end
            s1_op == OP_OR: begin
                res_f   = s1_a | s1_b;
                res_ref = s1_a | s1_b;
            end
            s1_op == OP_SLL: begin
                res_f   = s1_a << shamt_f;
                res_ref = s1_a << s1_shamt;
            end
            s1_op == OP_SRA: begin
                res_f   = $unsigned($signed(s1_a) >>> shamt_f);
                res_ref = $unsigned($signed(s1_a) >>> s1_shamt);
            end
            default: begin
                res_f   = '0;
                res_ref = '0;
            end
        endcase
        if (s1_fsel == 2'd2 && s1_op <= OP_SRA) res_f = res_f ^ bit_mask;
        diff = s1_a - s1_b;
        ne_c = (s1_a != s1_b);
        lt_c = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) ? s1_a[WIDTH-1]
                                                : diff[WIDTH-1];
    end

    // Stage 2: result register, held while the consumer stalls
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid      <= 1'b0;
            data_result    <= '0;
            isNotEqual     <= 1'b0;
            isLessThan     <= 1'b0;
            fault_detected <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_result    <= res_f;
                isNotEqual     <= ne_c;
                isLessThan     <= lt_c;
                fault_detected <= (res_f != res_ref);
            end
        end
    end

    // Error accounting; a detection coincident with clear counts once
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (clear_err) begin
            err_sticky <= xfer_det;
            err_count  <= xfer_det ? ERRCNT_W'(1) : '0;
        end else if (xfer_det) begin
            err_sticky <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_fault_pipe.sv
// tb_alu_fault_pipe: directed checks of pipeline timing, ALU ops,
// fault injection/detection, stalls, counter saturation and reset.
module tb_alu_fault_pipe;

    localparam logic [4:0] ADD = 5'd0;
    localparam logic [4:0] SUB = 5'd1;
    localparam logic [4:0] AND_ = 5'd2;
    localparam logic [4:0] OR_ = 5'd3;
    localparam logic [4:0] SLL = 5'd4;
    localparam logic [4:0] SRA = 5'd5;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic        fault_arm;
    logic [1:0]  fault_sel;
    logic [4:0]  fault_bit;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        fault_detected;
    logic        clear_err;
    logic        err_sticky;
    logic [1:0]  err_count;

    int checks = 0;
    int failures = 0;

    alu_fault_pipe #(.WIDTH(32), .SHAMT_W(5), .ERRCNT_W(2)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .fault_arm(fault_arm), .fault_sel(fault_sel), .fault_bit(fault_bit),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(data_result), .isNotEqual(isNotEqual),
        .isLessThan(isLessThan), .fault_detected(fault_detected),
        .clear_err(clear_err), .err_sticky(err_sticky), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
        in_valid = 1'b1;
        ctrl_ALUopcode = op;
        data_operandA = a;
        data_operandB = b;
        ctrl_shiftamt = sh;
    endtask

    task automatic arm(input logic [1:0] s, input logic [4:0] b);
        fault_arm = 1'b1;
        fault_sel = s;
        fault_bit = b;
    endtask

    task automatic arm_alone(input logic [1:0] s, input logic [4:0] b);
        arm(s, b);
        tick;
        fault_arm = 1'b0;
    endtask

    // Accept one op and stop where its result is on the outputs
    task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        drive_op(op, a, b, sh);
        tick;
        in_valid = 1'b0;
        tick;
    endtask

    task automatic do_clear;
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, data_result, isNotEqual, isLessThan,
             fault_detected, err_sticky, err_count} !==
            {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL reset_state got ov=%b ir=%b res=%h fd=%b st=%b cnt=%0d",
                     out_valid, in_ready, data_result, fault_detected,
                     err_sticky, err_count);
        end
        tick;
        tick;
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_latency;
        out_ready = 1'b1;
        drive_op(ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got ov=%b exp 0", out_valid);
        end
        tick;
        checks++;
        if ({out_valid, data_result, isNotEqual, isLessThan, fault_detected} !==
            {1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_overflow got ov=%b res=%h ne=%b lt=%b fd=%b exp 1 80000000 1 0 0",
                     out_valid, data_result, isNotEqual, isLessThan, fault_detected);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_out got ov=%b exp 0", out_valid);
        end
    endtask

    task automatic test_ops;
        logic [4:0]  op [8] = '{ADD, SUB, AND_, OR_, SLL, SRA, 5'd7, SUB};
        logic [31:0] a  [8] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hF0F0_1234,
                                32'hF0F0_1234, 32'h3, 32'h8000_0000, 32'h5, 32'h5};
        logic [31:0] b  [8] = '{32'hFFFF_FFFF, 32'h1, 32'h0FF0_FF00,
                                32'h0FF0_FF00, 32'h3, 32'h0, 32'h9, 32'h9};
        logic [4:0]  sh [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd0};
        logic [31:0] er [8] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h00F0_1200,
                                32'hFFF0_FF34, 32'h30, 32'hF800_0000, 32'h0,
                                32'hFFFF_FFFC};
        logic [1:0]  ef [8] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11,
                                2'b11, 2'b11};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(op[i], a[i], b[i], sh[i]);
            checks++;
            if ({out_valid, data_result, isNotEqual, isLessThan, fault_detected} !==
                {1'b1, er[i], ef[i], 1'b0}) begin
                failures++;
                $display("FAIL op_row%0d got ov=%b res=%h ne=%b lt=%b fd=%b exp res=%h ne/lt=%b",
                         i, out_valid, data_result, isNotEqual, isLessThan,
                         fault_detected, er[i], ef[i]);
            end
            tick;
        end
    endtask

    task automatic test_fault_sum;
        out_ready = 1'b1;
        do_clear;
        arm_alone(2'd0, 5'd3);
        drive_op(SUB, 32'd10, 32'd3, 5'd0);
        tick;
        tick;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, data_result, fault_detected} !== {1'b1, 32'hF, 1'b1}) begin
            failures++;
            $display("FAIL sum_fault got ov=%b res=%h fd=%b exp 1 0000000f 1",
                     out_valid, data_result, fault_detected);
        end
        tick;
        checks++;
        if ({out_valid, data_result, fault_detected, err_count, err_sticky} !==
            {1'b1, 32'h7, 1'b0, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL sum_oneshot got ov=%b res=%h fd=%b cnt=%0d st=%b exp 1 7 0 1 1",
                     out_valid, data_result, fault_detected, err_count, err_sticky);
        end
        tick;
    endtask

    task automatic test_fault_shamt;
        out_ready = 1'b1;
        do_clear;
        arm_alone(2'd1, 5'd0);
        run_op(SRA, 32'h8000_0000, 32'h0, 5'd4);
        checks++;
        if ({data_result, fault_detected} !== {32'hFC00_0000, 1'b1}) begin
            failures++;
            $display("FAIL shamt_fault got res=%h fd=%b exp fc000000 1",
                     data_result, fault_detected);
        end
        tick;
        arm_alone(2'd1, 5'd0);
        run_op(SRA, 32'h0, 32'h0, 5'd4);
        checks++;
        if ({data_result, fault_detected} !== {32'h0, 1'b0}) begin
            failures++;
            $display("FAIL shamt_masked got res=%h fd=%b exp 0 0",
                     data_result, fault_detected);
        end
        tick;
        checks++;
        if (err_count !== 2'd1) begin
            failures++;
            $display("FAIL shamt_count got %0d exp 1", err_count);
        end
    endtask

    task automatic test_fault_misc;
        out_ready = 1'b1;
        arm_alone(2'd0, 5'd2);
        run_op(AND_, 32'hFF, 32'h0F, 5'd0);
        checks++;
        if ({data_result, fault_detected} !== {32'h0F, 1'b0}) begin
            failures++;
            $display("FAIL and_masked got res=%h fd=%b exp 0000000f 0",
                     data_result, fault_detected);
        end
        tick;
        arm_alone(2'd2, 5'd4);
        run_op(5'd7, 32'h1, 32'h2, 5'd0);
        checks++;
        if ({data_result, fault_detected} !== {32'h0, 1'b0}) begin
            failures++;
            $display("FAIL illegal_op got res=%h fd=%b exp 0 0",
                     data_result, fault_detected);
        end
        tick;
        arm_alone(2'd2, 5'd31);
        run_op(OR_, 32'h1, 32'h2, 5'd0);
        checks++;
        if ({data_result, fault_detected} !== {32'h8000_0003, 1'b1}) begin
            failures++;
            $display("FAIL result_fault got res=%h fd=%b exp 80000003 1",
                     data_result, fault_detected);
        end
        tick;
        arm_alone(2'd0, 5'd0);
        arm_alone(2'd3, 5'd0);
        run_op(ADD, 32'h2, 32'h2, 5'd0);
        checks++;
        if ({data_result, fault_detected} !== {32'h4, 1'b0}) begin
            failures++;
            $display("FAIL disarm got res=%h fd=%b exp 4 0",
                     data_result, fault_detected);
        end
        tick;
        drive_op(ADD, 32'h2, 32'h2, 5'd0);
        arm(2'd2, 5'd0);
        tick;
        fault_arm = 1'b0;
        tick;
        in_valid = 1'b0;
        checks++;
        if ({data_result, fault_detected} !== {32'h4, 1'b0}) begin
            failures++;
            $display("FAIL idle_arm_same got res=%h fd=%b exp 4 0",
                     data_result, fault_detected);
        end
        tick;
        checks++;
        if ({out_valid, data_result, fault_detected} !== {1'b1, 32'h5, 1'b1}) begin
            failures++;
            $display("FAIL idle_arm_next got ov=%b res=%h fd=%b exp 1 5 1",
                     out_valid, data_result, fault_detected);
        end
        tick;
    endtask

    task automatic test_stall;
        int sent = 0;
        int got = 0;
        bit saw_block = 0;
        bit hold_chk = 0;
        logic [32:0] held = '0;
        logic [31:0] exp_r;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (sent < 4)
                drive_op(ADD, 32'h1000 * (sent + 1), 32'(sent + 1), 5'd0);
            else
                in_valid = 1'b0;
            #1;
            if (hold_chk) begin
                checks++;
                if ({data_result, fault_detected} !== held) begin
                    failures++;
                    $display("FAIL stall_hold got %h exp %h",
                             {data_result, fault_detected}, held);
                end
            end
            hold_chk = 0;
            if (out_valid && !out_ready) begin
                held = {data_result, fault_detected};
                hold_chk = 1;
            end
            if (sent < 4 && !in_ready) saw_block = 1;
            if (out_valid && out_ready) begin
                exp_r = 32'h1000 * (got + 1) + 32'(got + 1);
                checks++;
                if (data_result !== exp_r) begin
                    failures++;
                    $display("FAIL stream_%0d got %h exp %h", got, data_result, exp_r);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if ({got, sent, saw_block} !== {32'd4, 32'd4, 1'b1}) begin
            failures++;
            $display("FAIL stream_count got out=%0d in=%0d blocked=%b exp 4 4 1",
                     got, sent, saw_block);
        end
        tick;
    endtask

    task automatic test_saturate;
        out_ready = 1'b1;
        do_clear;
        arm_alone(2'd2, 5'd0);
        for (int k = 0; k < 4; k++) begin
            drive_op(ADD, 32'h1, 32'h1, 5'd0);
            if (k < 3) arm(2'd2, 5'd0);
            else fault_arm = 1'b0;
            tick;
        end
        in_valid = 1'b0;
        fault_arm = 1'b0;
        tick;
        tick;
        checks++;
        if ({err_count, err_sticky} !== {2'd3, 1'b1}) begin
            failures++;
            $display("FAIL saturate got cnt=%0d st=%b exp 3 1", err_count, err_sticky);
        end
        arm_alone(2'd2, 5'd0);
        run_op(ADD, 32'h1, 32'h1, 5'd0);
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
        checks++;
        if ({err_count, err_sticky} !== {2'd1, 1'b1}) begin
            failures++;
            $display("FAIL clear_same got cnt=%0d st=%b exp 1 1", err_count, err_sticky);
        end
    endtask

    task automatic test_reset_midop;
        out_ready = 1'b0;
        arm_alone(2'd2, 5'd0);
        drive_op(ADD, 32'h1, 32'h1, 5'd0);
        arm(2'd2, 5'd0);
        tick;
        drive_op(ADD, 32'h3, 32'h3, 5'd0);
        tick;
        in_valid = 1'b0;
        fault_arm = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, err_count, err_sticky, data_result} !==
            {1'b0, 1'b1, 2'd0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid got ov=%b ir=%b cnt=%0d st=%b res=%h",
                     out_valid, in_ready, err_count, err_sticky, data_result);
        end
        tick;
        resetn = 1'b1;
        out_ready = 1'b1;
        drive_op(ADD, 32'h1, 32'h1, 5'd0);
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush got ov=%b exp 0", out_valid);
        end
        tick;
        checks++;
        if ({out_valid, data_result, fault_detected} !== {1'b1, 32'h2, 1'b0}) begin
            failures++;
            $display("FAIL reset_disarm got ov=%b res=%h fd=%b exp 1 2 0",
                     out_valid, data_result, fault_detected);
        end
        tick;
    endtask

    initial begin
        in_valid = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        ctrl_ALUopcode = '0;
        ctrl_shiftamt = '0;
        fault_arm = 1'b0;
        fault_sel = 2'd3;
        fault_bit = '0;
        out_ready = 1'b1;
        clear_err = 1'b0;
        resetn = 1'b0;
        test_reset;
        test_latency;
        test_ops;
        test_fault_sum;
        test_fault_shamt;
        test_fault_misc;
        test_stall;
        test_saturate;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
